// File: rtl/spi_stream_bridge_if.sv
// Signal bundle for spi_stream_bridge: producer/consumer byte streams, SPI master
// control port, FIFO levels and the stray-done status flag.
interface spi_stream_bridge_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             m_valid;
    logic [7:0]       m_data;
    logic             m_ready;
    logic             spi_start;
    logic [7:0]       spi_tx_data;
    logic [7:0]       spi_rx_data;
    logic             spi_busy;
    logic             spi_done;
    logic [LVL_W-1:0] tx_level;
    logic [LVL_W-1:0] rx_level;
    logic             err_stray_done;
    logic             err_clr;

    // Bridge side
    modport master (
        input  s_valid, s_data, m_ready, spi_rx_data, spi_busy, spi_done, err_clr,
        output s_ready, m_valid, m_data, spi_start, spi_tx_data, tx_level, rx_level,
               err_stray_done
    );

    // Environment side: producer, consumer, SPI master core and status reader
    modport slave (
        output s_valid, s_data, m_ready, spi_rx_data, spi_busy, spi_done, err_clr,
        input  s_ready, m_valid, m_data, spi_start, spi_tx_data, tx_level, rx_level,
               err_stray_done
    );
endinterface

// File: rtl/spi_stream_bridge.sv
// Byte-stream front end for an SPI master: TX FIFO feeds one transfer per byte,
// received bytes land in an RX FIFO whose space is reserved before each start.
module spi_stream_bridge #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_stream_bridge_if.master bus
);
    localparam int unsigned      LVL_W        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned      PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL     = LVL_W'(FIFO_DEPTH);
    localparam logic [0:0]       ST_IDLE      = 1'b0;
    localparam logic [0:0]       ST_WAIT_DONE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [7:0]       tx_mem_d [FIFO_DEPTH];
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [7:0]       rx_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PTR_W-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [LVL_W-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             spi_start_q, spi_start_d;
    logic [7:0]       spi_tx_data_q, spi_tx_data_d;
    logic             err_q, err_d;

    logic tx_push, tx_pop, rx_push, rx_pop, stray_done;

    // Transfer launch condition: data queued, master idle, RX slot reserved
    always_comb begin
        tx_push    = bus.s_valid && s_ready_q;
        rx_pop     = m_valid_q && bus.m_ready;
        tx_pop     = (state_q == ST_IDLE) && (tx_level_q != '0) && !bus.spi_busy &&
                     (rx_level_q < LVL_FULL);
        rx_push    = (state_q == ST_WAIT_DONE) && bus.spi_done;
        stray_done = (state_q != ST_WAIT_DONE) && bus.spi_done;
    end

    // FSM: one transfer in flight at a time
    always_comb begin
        state_d       = state_q;
        spi_start_d   = 1'b0;
        spi_tx_data_d = spi_tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_pop) begin
                    spi_tx_data_d = tx_mem_q[tx_rd_q];
                    spi_start_d   = 1'b1;
                    state_d       = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.spi_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = err_q;
        if (stray_done) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    // FIFO pointers, storage and levels
    always_comb begin
        tx_mem_d   = tx_mem_q;
        rx_mem_d   = rx_mem_q;
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        tx_level_d = tx_level_q;
        rx_level_d = rx_level_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = bus.s_data;
            tx_wr_d           = tx_wr_q + PTR_W'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + PTR_W'(1);
        end
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + LVL_W'(1);
        end else if (!tx_push && tx_pop) begin
            tx_level_d = tx_level_q - LVL_W'(1);
        end
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = bus.spi_rx_data;
            rx_wr_d           = rx_wr_q + PTR_W'(1);
        end
        if (rx_pop) begin
            rx_rd_d = rx_rd_q + PTR_W'(1);
        end
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + LVL_W'(1);
        end else if (!rx_push && rx_pop) begin
            rx_level_d = rx_level_q - LVL_W'(1);
        end
        // Outputs registered from next-state so they track the levels exactly
        s_ready_d = (tx_level_d != LVL_FULL);
        m_valid_d = (rx_level_d != '0);
        m_data_d  = rx_mem_d[rx_rd_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wr_q       <= '0;
            tx_rd_q       <= '0;
            rx_wr_q       <= '0;
            rx_rd_q       <= '0;
            tx_level_q    <= '0;
            rx_level_q    <= '0;
            s_ready_q     <= 1'b1;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            spi_start_q   <= 1'b0;
            spi_tx_data_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_mem_q      <= tx_mem_d;
            rx_mem_q      <= rx_mem_d;
            tx_wr_q       <= tx_wr_d;
            tx_rd_q       <= tx_rd_d;
            rx_wr_q       <= rx_wr_d;
            rx_rd_q       <= rx_rd_d;
            tx_level_q    <= tx_level_d;
            rx_level_q    <= rx_level_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            spi_start_q   <= spi_start_d;
            spi_tx_data_q <= spi_tx_data_d;
            err_q         <= err_d;
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_data         = m_data_q;
    assign bus.spi_start      = spi_start_q;
    assign bus.spi_tx_data    = spi_tx_data_q;
    assign bus.tx_level       = tx_level_q;
    assign bus.rx_level       = rx_level_q;
    assign bus.err_stray_done = err_q;
endmodule

// File: tb/tb_spi_stream_bridge.sv
// Bench for spi_stream_bridge: queue-based reference model checked every cycle,
// an echoing SPI master model, directed scenarios and a randomized run.
module tb_spi_stream_bridge;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_stream_bridge_if #(.FIFO_DEPTH(DEPTH)) bus ();
    spi_stream_bridge #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two byte queues, a transfer-in-flight flag and the sticky error
    logic [7:0] mtx[$];
    logic [7:0] mrx[$];
    bit         m_wait  = 1'b0;
    bit         m_start = 1'b0;
    logic [7:0] m_txd   = 8'h00;
    bit         m_err   = 1'b0;

    task automatic model_reset();
        mtx.delete();
        mrx.delete();
        m_wait  = 1'b0;
        m_start = 1'b0;
        m_txd   = 8'h00;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        bit push, pop_rx, launch, done_ok, stray;
        push    = bus.s_valid && (mtx.size() < DEPTH);
        pop_rx  = (mrx.size() != 0) && bus.m_ready;
        launch  = !m_wait && (mtx.size() != 0) && !bus.spi_busy && (mrx.size() < DEPTH);
        done_ok = m_wait && bus.spi_done;
        stray   = !m_wait && bus.spi_done;
        if (launch) m_txd = mtx.pop_front();
        if (push) mtx.push_back(bus.s_data);
        if (pop_rx) void'(mrx.pop_front());
        if (done_ok) mrx.push_back(bus.spi_rx_data);
        m_start = launch;
        if (launch) m_wait = 1'b1;
        else if (done_ok) m_wait = 1'b0;
        if (stray) m_err = 1'b1;
        else if (bus.err_clr) m_err = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        chk("s_ready", 32'(bus.s_ready), 32'(mtx.size() != DEPTH));
        chk("m_valid", 32'(bus.m_valid), 32'(mrx.size() != 0));
        if (mrx.size() != 0) chk("m_data", 32'(bus.m_data), 32'(mrx[0]));
        chk("spi_start", 32'(bus.spi_start), 32'(m_start));
        chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(m_txd));
        chk("tx_level", 32'(bus.tx_level), 32'(mtx.size()));
        chk("rx_level", 32'(bus.rx_level), 32'(mrx.size()));
        chk("err_stray_done", 32'(bus.err_stray_done), 32'(m_err));
    end

    // Stimulus state: producer queue, SPI master model, consumer mode
    logic [7:0] prod_q[$];
    bit         acc_prev     = 1'b0;
    bit         start_prev   = 1'b0;
    bit         mst_busy     = 1'b0;
    int         mst_cnt      = 0;
    logic [7:0] mst_tx       = 8'h00;
    bit         force_busy   = 1'b0;
    int         lat_min      = 0;
    int         lat_max      = 0;
    int         mready_mode  = 0;
    int         stray_pct    = 0;
    int         clr_pct      = 0;
    bit         inject_stray = 1'b0;
    bit         pulse_clr    = 1'b0;
    int         n_starts     = 0;

    initial forever begin
        @(negedge clk);
        acc_prev   = bus.s_valid && bus.s_ready;
        start_prev = bus.spi_start;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (acc_prev && prod_q.size() != 0) void'(prod_q.pop_front());
        bus.s_valid  = (prod_q.size() != 0);
        bus.s_data   = (prod_q.size() != 0) ? prod_q[0] : 8'h00;
        bus.spi_done = 1'b0;
        if (start_prev) begin
            n_starts++;
            mst_busy = 1'b1;
            mst_tx   = bus.spi_tx_data;
            mst_cnt  = int'($urandom_range(lat_max, lat_min));
        end else if (mst_busy) begin
            if (mst_cnt == 0) begin
                bus.spi_done    = 1'b1;
                bus.spi_rx_data = mst_tx ^ 8'h99;
                mst_busy        = 1'b0;
            end else begin
                mst_cnt--;
            end
        end
        if (!bus.spi_done && (inject_stray || (int'($urandom_range(99, 0)) < stray_pct))) begin
            bus.spi_done    = 1'b1;
            bus.spi_rx_data = 8'($urandom);
        end
        inject_stray = 1'b0;
        bus.spi_busy = mst_busy || force_busy;
        bus.err_clr  = pulse_clr || (int'($urandom_range(99, 0)) < clr_pct);
        pulse_clr    = 1'b0;
        case (mready_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            default: bus.m_ready = 1'($urandom_range(1, 0));
        endcase
    endtask

    task automatic run_idle(input int max_cyc, input string tag);
        int n = 0;
        while (!(prod_q.size() == 0 && mtx.size() == 0 && !m_wait && !mst_busy) && n < max_cyc) begin
            cyc();
            n++;
        end
        n_tests++;
        if (n >= max_cyc) begin
            n_fail++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
        chk({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
        chk({tag, "_spi_start"}, 32'(bus.spi_start), 32'd0);
        chk({tag, "_spi_tx_data"}, 32'(bus.spi_tx_data), 32'd0);
        chk({tag, "_tx_level"}, 32'(bus.tx_level), 32'd0);
        chk({tag, "_rx_level"}, 32'(bus.rx_level), 32'd0);
        chk({tag, "_err"}, 32'(bus.err_stray_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bus.s_valid     = 1'b0;
        bus.s_data      = 8'h00;
        bus.m_ready     = 1'b0;
        bus.spi_rx_data = 8'h00;
        bus.spi_busy    = 1'b0;
        bus.spi_done    = 1'b0;
        bus.err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("por");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Single byte, slow echo
        lat_min = 16; lat_max = 16; mready_mode = 0;
        s0 = n_starts;
        prod_q.push_back(8'hA5);
        run_idle(200, "single");
        repeat (2) cyc();
        chk("single_starts", 32'(n_starts - s0), 32'd1);
        chk("single_tx_data", 32'(bus.spi_tx_data), 32'hA5);
        chk("single_m_data", 32'(bus.m_data), 32'h3C);
        chk("single_m_valid", 32'(bus.m_valid), 32'd1);
        chk("single_rx_level", 32'(bus.rx_level), 32'd1);
        mready_mode = 1;
        repeat (3) cyc();

        // Back-to-back burst of 8
        lat_min = 0; lat_max = 2;
        s0 = n_starts;
        for (int i = 1; i <= 8; i++) prod_q.push_back(8'(i));
        run_idle(300, "burst");
        repeat (3) cyc();
        chk("burst_starts", 32'(n_starts - s0), 32'd8);
        chk("burst_rx_level", 32'(bus.rx_level), 32'd0);

        // Fill TX while the master is held busy
        force_busy = 1'b1;
        s0 = n_starts;
        for (int i = 0; i < 9; i++) prod_q.push_back(8'(8'h10 + i));
        repeat (15) cyc();
        chk("full_tx_level", 32'(bus.tx_level), 32'd8);
        chk("full_s_ready", 32'(bus.s_ready), 32'd0);
        chk("full_no_start", 32'(n_starts - s0), 32'd0);
        chk("full_held_bytes", 32'(prod_q.size()), 32'd1);
        force_busy = 1'b0;
        run_idle(400, "full");
        repeat (3) cyc();
        chk("full_starts", 32'(n_starts - s0), 32'd9);

        // RX back-pressure: 10 bytes with consumer stalled
        mready_mode = 0; lat_min = 1; lat_max = 1;
        s0 = n_starts;
        for (int i = 0; i < 10; i++) prod_q.push_back(8'($urandom));
        repeat (120) cyc();
        chk("bp_starts", 32'(n_starts - s0), 32'd8);
        chk("bp_rx_level", 32'(bus.rx_level), 32'd8);
        chk("bp_tx_level", 32'(bus.tx_level), 32'd2);
        mready_mode = 1;
        cyc();
        mready_mode = 0;
        repeat (30) cyc();
        chk("bp_one_more", 32'(n_starts - s0), 32'd9);
        chk("bp_rx_level2", 32'(bus.rx_level), 32'd8);
        chk("bp_tx_level2", 32'(bus.tx_level), 32'd1);
        mready_mode = 1;
        run_idle(300, "bp");
        repeat (5) cyc();

        // Stray done while idle, clear, and set-wins-over-clear
        inject_stray = 1'b1;
        cyc();
        cyc();
        chk("stray_err", 32'(bus.err_stray_done), 32'd1);
        chk("stray_rx_level", 32'(bus.rx_level), 32'd0);
        pulse_clr = 1'b1;
        cyc();
        cyc();
        chk("stray_clr", 32'(bus.err_stray_done), 32'd0);
        inject_stray = 1'b1;
        pulse_clr    = 1'b1;
        cyc();
        cyc();
        chk("stray_set_wins", 32'(bus.err_stray_done), 32'd1);
        pulse_clr = 1'b1;
        cyc();
        cyc();
        chk("stray_clr2", 32'(bus.err_stray_done), 32'd0);

        // Asynchronous reset during a transfer with bytes queued
        lat_min = 10; lat_max = 10;
        s0 = n_starts;
        for (int i = 0; i < 4; i++) prod_q.push_back(8'(8'hC0 + i));
        for (int n = 0; n < 20 && n_starts == s0; n++) cyc();
        repeat (4) cyc();
        chk("rst_pre_starts", 32'(n_starts - s0), 32'd1);
        chk("rst_pre_tx_level", 32'(bus.tx_level), 32'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async");
        prod_q.delete();
        bus.s_valid  = 1'b0;
        bus.spi_done = 1'b0;
        bus.spi_busy = 1'b0;
        mst_busy     = 1'b0;
        acc_prev     = 1'b0;
        start_prev   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (20) cyc();
        chk("rst_post_starts", 32'(n_starts - s0), 32'd1);
        chk("rst_post_tx_level", 32'(bus.tx_level), 32'd0);

        // Randomized traffic with random back-pressure, strays and clears
        lat_min = 0; lat_max = 4; mready_mode = 2; stray_pct = 2; clr_pct = 3;
        for (int i = 0; i < 200; i++) prod_q.push_back(8'($urandom));
        run_idle(6000, "random");
        stray_pct = 0; clr_pct = 0; mready_mode = 1;
        repeat (20) cyc();
        chk("random_drained", 32'(bus.rx_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_stream_bridge.md
Name: spi_stream_bridge

Overview:
- Byte-stream front end that sits directly upstream of the SPI master core and drives its start/tx_data/rx_data/busy/done control port.
- Buffers outgoing bytes from a valid/ready producer in a TX FIFO and issues one SPI transfer per byte.
- Each received byte is pushed into an RX FIFO, which a valid/ready consumer drains.
- Guarantees no RX loss by reserving RX space before every transfer.

Parameters:
- FIFO_DEPTH, 8, entries in each of TX and RX FIFO. Power of two, >= 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the level outputs. Derived; not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  producer byte valid.
- s_data  in  8  producer byte.
- s_ready  out  1  TX FIFO can accept.
- m_valid  out  1  RX byte available.
- m_data  out  8  RX byte (FIFO head).
- m_ready  in  1  consumer accepts.
- spi_start  out  1  one-cycle transfer request to SPI master.
- spi_tx_data  out  8  byte to shift out.
- spi_rx_data  in  8  byte shifted in; valid when spi_done=1.
- spi_busy  in  1  SPI master mid-transfer.
- spi_done  in  1  one-cycle transfer-complete pulse.
- tx_level  out  LVL_W  TX FIFO occupancy.
- rx_level  out  LVL_W  RX FIFO occupancy.
- err_stray_done  out  1  sticky: spi_done seen while not in WAIT_DONE.
- err_clr  in  1  clears err_stray_done.

Behaviour:
Reset is asynchronous and active-low on rst_n, single clock clk. All state clears on reset; there is no synchronous reset path.
- Reset values: FIFOs empty, s_ready=1, m_valid=0, m_data=0, spi_start=0, spi_tx_data=0, tx_level=0, rx_level=0, err_stray_done=0, FSM=IDLE.
- Reset mid-transfer: any in-flight byte is discarded. The SPI master shares rst_n.

TX FIFO:
- Push on s_valid && s_ready.
- s_ready = (tx_level != FIFO_DEPTH), registered-count based, with no combinational path from s_valid.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle are both legal; the level is unchanged.

RX FIFO:
- m_valid = (rx_level != 0). m_data = head entry, first-word fall-through.
- Pop on m_valid && m_ready.
- Push is the captured spi_rx_data. Simultaneous push and pop are legal.

FSM (registered):
- IDLE: when tx_level != 0, spi_busy == 0, and rx_level + rx_popping_adjust < FIFO_DEPTH (strict: rx_level < FIFO_DEPTH, evaluated on registered rx_level):
  - pop the TX head into spi_tx_data,
  - assert spi_start for exactly one cycle,
  - go to WAIT_DONE.
  - Otherwise stay in IDLE.
- WAIT_DONE: spi_start=0 and spi_tx_data held stable. On spi_done: push spi_rx_data into the RX FIFO that cycle, then go to IDLE.
- There is no timeout; the bridge waits indefinitely for spi_done.
- Only one transfer is in flight, so rx_level < FIFO_DEPTH at start guarantees the RX push always has room.

Timing:
- Byte accepted at edge E0 gives spi_start high in the cycle following E1 (minimum 1-cycle gap).
- spi_done at edge Ek gives the byte in RX at Ek+1, m_valid high from Ek+1.
- Back-to-back: after spi_done, the next spi_start is registered at the following edge, giving 1 idle cycle between done and the next start.

Errors:
- spi_done while FSM != WAIT_DONE sets err_stray_done, and the data is dropped.
- err_clr clears the flag. If err_clr and a stray done coincide, set wins.
- s_valid while full: the byte is not taken and the producer must hold it; no error is raised.

Levels: tx_level and rx_level are registered, update one cycle after the push/pop edge, and range 0..FIFO_DEPTH.

Test Plan:
- Reset then single byte 0xA5, master model echoes 0x3C after 16 clk → exactly one spi_start pulse, spi_tx_data=0xA5 held until done, m_data=0x3C, m_valid=1, rx_level=1.
- Push 8 bytes 0x01..0x08 back-to-back, m_ready=1 → s_ready stays 1, 8 starts in order, RX returns 8 echoes in order, tx_level peaks ≤ 8, 1 idle cycle between each done and next start.
- Fill TX with 8 bytes while spi_busy forced 1 → s_ready=0 at tx_level=8, 9th byte held by producer, no spi_start until spi_busy drops.
- m_ready=0, push 10 bytes → exactly 8 transfers occur, rx_level=8, FSM stalls in IDLE with tx_level=2; assert m_ready for 1 pop → exactly one more transfer starts.
- Inject spi_done in IDLE → err_stray_done=1 next cycle, RX unchanged; err_clr pulse → flag 0.
- Assert rst_n=0 during WAIT_DONE with 3 bytes queued → all outputs return to reset values immediately, tx_level=0; no spi_start after release until new data is pushed.
